// File: rtl/udp_tx_pkt_buffer_if.sv
// Byte-stream ingress and transmitter read port of the UDP TX packet buffer.
// master drives writes/requests; slave is the buffer itself.
interface udp_tx_pkt_buffer_if #(
  parameter int ADDR_W = 12
);
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              pix_sof;
  logic              send_start;
  logic              fifo_send_req;
  logic [9:0]        fifo_send_data;
  logic [ADDR_W:0]   occupancy;
  logic              overflow;
  logic              req_err;

  modport master (
    output pix_valid, pix_data, pix_sof, fifo_send_req,
    input  send_start, fifo_send_data, occupancy, overflow, req_err
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, fifo_send_req,
    output send_start, fifo_send_data, occupancy, overflow, req_err
  );
endinterface

// File: rtl/udp_tx_pkt_buffer.sv
// Circular packet staging RAM in front of the GMII UDP transmitter.
// Announces each full payload with send_start, then serves 1-cycle reads.
module udp_tx_pkt_buffer #(
  parameter logic [15:0] DATA_SIZE  = 16'd100,
  parameter int          ADDR_W     = 12,
  parameter int          GAP_CYCLES = 16
) (
  input  logic                 GMII_GTXCLK,
  input  logic                 rst_n,
  udp_tx_pkt_buffer_if.slave   bus
);
  localparam int PKT_BYTES = int'(DATA_SIZE) - 2;
  localparam int DEPTH     = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SENDING,
    GAP
  } state_t;

  state_t            state, state_nxt;
  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   occ;
  logic [10:0]       rd_cnt;
  logic [7:0]        gap_cnt;
  logic [9:0]        rd_data;
  logic              ovf, err;
  logic              full, empty, pkt_ready;
  logic              wr_acc, rd_acc, rd_last, gap_last;

  // occupancy never exceeds DEPTH, so its MSB alone means full
  assign full      = occ[ADDR_W];
  assign empty     = (occ == '0);
  assign pkt_ready = (occ >= (ADDR_W+1)'(PKT_BYTES));
  assign wr_acc    = bus.pix_valid && !full;
  assign rd_acc    = (state == SENDING) && bus.fifo_send_req && !empty;
  assign rd_last   = (rd_cnt == 11'(PKT_BYTES - 1));
  assign gap_last  = (gap_cnt == 8'(GAP_CYCLES - 1));

  always_ff @(posedge GMII_GTXCLK) begin
    if (wr_acc)
      mem[wr_ptr] <= {1'b0, bus.pix_sof, bus.pix_data};
  end

  always_ff @(posedge GMII_GTXCLK) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pkt_ready) state_nxt = ARM;
      ARM:     state_nxt = SENDING;
      SENDING: if (rd_acc && rd_last) state_nxt = GAP;
      GAP:     if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge GMII_GTXCLK) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      rd_cnt  <= '0;
      gap_cnt <= '0;
      rd_data <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (bus.pix_valid && full)
        ovf <= 1'b1;
      if (bus.fifo_send_req && !rd_acc)
        err <= 1'b1;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
        rd_cnt  <= rd_last ? '0 : rd_cnt + 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (state == GAP)
        gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
    end
  end

  assign bus.send_start     = (state == ARM);
  assign bus.fifo_send_data = rd_data;
  assign bus.occupancy      = occ;
  assign bus.overflow       = ovf;
  assign bus.req_err        = err;
endmodule

// File: tb/tb_udp_tx_pkt_buffer.sv
// Directed + randomized bench for udp_tx_pkt_buffer against a queue model.
// Small RAM (ADDR_W=8) so overflow and pointer wrap are reachable.
module tb_udp_tx_pkt_buffer;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PKT    = 98;
  localparam int GAPC   = 16;

  logic GMII_GTXCLK = 1'b0;
  logic rst_n;

  always #4 GMII_GTXCLK = ~GMII_GTXCLK;

  udp_tx_pkt_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  udp_tx_pkt_buffer #(
    .DATA_SIZE  (16'd100),
    .ADDR_W     (ADDR_W),
    .GAP_CYCLES (GAPC)
  ) dut (
    .GMII_GTXCLK (GMII_GTXCLK),
    .rst_n       (rst_n),
    .bus         (bus.slave)
  );

  // reference model: FIFO contents plus packet phase bookkeeping
  localparam int P_IDLE = 0, P_ARM = 1, P_SEND = 2, P_GAP = 3;
  logic [9:0] q [$];
  int         m_ph;
  int         m_left;
  int         m_gap_left;
  logic [9:0] m_data;
  logic       m_ovf, m_err;

  int n_chk  = 0;
  int n_fail = 0;
  string tag = "";

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, name, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("send_start", 32'(bus.send_start), 32'(m_ph == P_ARM));
    chk("fifo_send_data", 32'(bus.fifo_send_data), 32'(m_data));
    chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("req_err", 32'(bus.req_err), 32'(m_err));
  endtask

  task automatic model_reset();
    q.delete();
    m_ph       = P_IDLE;
    m_left     = 0;
    m_gap_left = 0;
    m_data     = '0;
    m_ovf      = 1'b0;
    m_err      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.pix_valid     = 1'b0;
    bus.pix_data      = '0;
    bus.pix_sof       = 1'b0;
    bus.fifo_send_req = 1'b0;
    @(posedge GMII_GTXCLK);
    model_reset();
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d,
                       input logic s, input logic r);
    int  sz;
    int  ph0;
    bit  rd, wr;
    bus.pix_valid     = v;
    bus.pix_data      = d;
    bus.pix_sof       = s;
    bus.fifo_send_req = r;
    @(posedge GMII_GTXCLK);
    sz  = q.size();
    ph0 = m_ph;
    rd  = (ph0 == P_SEND) && r && (sz > 0);
    wr  = v && (sz < DEPTH);
    if (r && !rd) m_err = 1'b1;
    if (v && !wr) m_ovf = 1'b1;
    if (rd) m_data = q.pop_front();
    if (wr) q.push_back({1'b0, s, d});
    case (ph0)
      P_IDLE: if (sz >= PKT) m_ph = P_ARM;
      P_ARM: begin
        m_ph   = P_SEND;
        m_left = PKT;
      end
      P_SEND: if (rd) begin
        m_left--;
        if (m_left == 0) begin
          m_ph       = P_GAP;
          m_gap_left = GAPC;
        end
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) m_ph = P_IDLE;
      end
    endcase
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic write_seq(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 8'(i), (i == 0), 1'b0);
  endtask

  task automatic write_rand(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_send();
    int k = 0;
    while (m_ph != P_SEND && k < 8) begin
      idle(1);
      k++;
    end
    if (m_ph != P_SEND) begin
      n_fail++;
      $display("FAIL %s/wait_send: phase %0d expected %0d", tag, m_ph, P_SEND);
    end
  endtask

  initial begin
    int written;
    int cyc;
    model_reset();

    tag = "reset";
    do_reset();
    idle(2);

    tag = "basic";
    write_seq(PKT);
    wait_send();
    read_n(PKT);
    idle(GAPC + 2);

    tag = "idle_req";
    read_n(1);
    idle(2);

    tag = "overflow";
    do_reset();
    write_rand(DEPTH + 4);
    read_n(PKT);
    idle(GAPC + 1);
    wait_send();
    read_n(PKT);
    idle(GAPC + 3);

    tag = "simul_rw";
    do_reset();
    write_rand(PKT);
    wait_send();
    read_n(PKT - 1);
    cycle(1'b1, 8'h5a, 1'b1, 1'b1);
    idle(GAPC + 2);

    tag = "mid_reset";
    do_reset();
    write_rand(PKT);
    wait_send();
    read_n(40);
    do_reset();
    write_seq(PKT);
    wait_send();
    read_n(PKT);
    idle(GAPC + 2);

    tag = "wrap_rand";
    do_reset();
    written = 0;
    cyc     = 0;
    while ((written < 5 * PKT || q.size() > 0 || m_ph != P_IDLE)
           && cyc < 6000) begin
      logic v, r;
      v = (written < 5 * PKT) && ($urandom_range(0, 3) != 0);
      r = (m_ph == P_SEND) && ($urandom_range(0, 3) != 0);
      cycle(v, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), r);
      if (v) written++;
      cyc++;
    end
    if (cyc >= 6000) begin
      n_fail++;
      $display("FAIL wrap_rand/timeout: cycles %0d limit %0d", cyc, 6000);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
